// File: rtl/ahb_proto_checker.sv
// Passive AHB protocol checker: tracks bursts and expected SEQ addresses, evaluates ten bus rules
// and reports per-rule pulses, sticky flags, a saturating violation count and the first bad address.
//
// state      | meaning
// NO_BURST   | no burst tracked (idle, SINGLE, or burst finished/aborted)
// IN_BURST   | inside a multi-beat burst, last accepted beat was NONSEQ/SEQ
// IN_BUSY    | inside a burst, master is inserting BUSY cycles
module ahb_proto_checker #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 16,
   parameter int NCHK     = 10
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic [1:0]        HTRANS,
   input  logic [2:0]        HBURST,
   input  logic [2:0]        HSIZE,
   input  logic              HWRITE,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic              HREADY,
   input  logic [1:0]        HRESP,
   input  logic [NCHK-1:0]   chk_en,
   input  logic              clr,
   output logic [NCHK-1:0]   viol_pulse,
   output logic [NCHK-1:0]   viol_sticky,
   output logic [CNT_W-1:0]  viol_count,
   output logic [ADDR_W-1:0] first_addr,
   output logic              first_valid,
   output logic              burst_active,
   output logic [4:0]        beat_cnt
);

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NSEQ = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;
   localparam logic [1:0] R_OKAY = 2'd0;
   localparam logic [2:0] B_SINGLE = 3'd0;
   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
   localparam int         WW       = $clog2(MAX_WAIT + 2);
   localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_NO_BURST, S_IN_BURST, S_IN_BUSY} state_t;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: burst_len = 5'd4;
         3'd4, 3'd5: burst_len = 5'd8;
         3'd6, 3'd7: burst_len = 5'd16;
         default:    burst_len = 5'd0;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [2:0] burst);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] mask;
      inc = a + (ADDR_W'(1) << size);
      case (burst)
         3'd2:    mask = (ADDR_W'(4) << size) - ADDR_W'(1);
         3'd4:    mask = (ADDR_W'(8) << size) - ADDR_W'(1);
         3'd6:    mask = (ADDR_W'(16) << size) - ADDR_W'(1);
         default: mask = '0;
      endcase
      if (mask == '0) next_addr = inc;
      else            next_addr = (a & ~mask) | (inc & mask);
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          burst_q, burst_d;
   logic [2:0]          size_q, size_d;
   logic                write_q, write_d;
   logic [4:0]          beat_q, beat_d;
   logic [ADDR_W-1:0]   exp_q, exp_d;
   logic [ADDR_W-1:0]   prev_q, prev_d;
   logic                err_q, err_d;
   logic                ended_q, ended_d;
   logic                resp1_q, resp1_d;
   logic [1:0]          resp_q, resp_d;
   logic                idle_dp_q, idle_dp_d;
   logic [WW-1:0]       wait_q, wait_d;
   logic [NCHK-1:0]     pulse_q, pulse_d;
   logic [NCHK-1:0]     sticky_q, sticky_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   faddr_q, faddr_d;
   logic                fvalid_q, fvalid_d;

   logic                acc_nseq, acc_seq, acc, in_burst, err_seen, final_beat, any_v;
   logic [4:0]          len_q, beat_inc;
   logic [6:0]          size_mask;
   logic [NCHK-1:0]     viol_raw, viol_v;

   always_comb begin
      acc_nseq   = HREADY && (HTRANS == T_NSEQ);
      acc_seq    = HREADY && (HTRANS == T_SEQ);
      acc        = acc_nseq || acc_seq;
      in_burst   = (state_q != S_NO_BURST);
      len_q      = burst_len(burst_q);
      beat_inc   = (beat_q == 5'd31) ? beat_q : beat_q + 5'd1;
      final_beat = acc_seq && in_burst && (len_q != 5'd0) && (beat_inc == len_q);
      err_seen   = err_q || (HRESP != R_OKAY);
      size_mask  = 7'((8'd1 << HSIZE) - 8'd1);

      viol_raw = '0;
      // A non-OKAY response needs a wait cycle followed by a ready cycle with IDLE
      if (resp1_q) viol_raw[0] = !(HREADY && (HRESP == resp_q) && (HTRANS == T_IDLE));
      else         viol_raw[0] = HREADY && (HRESP != R_OKAY);
      viol_raw[1] = idle_dp_q && !(HREADY && (HRESP == R_OKAY));
      viol_raw[2] = HREADY && (HTRANS == T_BUSY) &&
                    ((state_q == S_NO_BURST) || (burst_q == B_SINGLE));
      viol_raw[3] = acc_seq && in_burst && (HADDR != exp_q);
      viol_raw[4] = acc_seq && in_burst &&
                    ((HBURST != burst_q) || (HSIZE != size_q) || (HWRITE != write_q));
      viol_raw[5] = acc_seq && in_burst && burst_q[0] &&
                    (HADDR[ADDR_W-1:10] != prev_q[ADDR_W-1:10]);
      viol_raw[6] = acc && (|(HADDR[6:0] & size_mask));
      viol_raw[7] = HREADY &&
                    (((HTRANS == T_SEQ) && !in_burst && ended_q) ||
                     (((HTRANS == T_NSEQ) || (HTRANS == T_IDLE)) && in_burst &&
                      (len_q != 5'd0) && (beat_q < len_q) && !err_seen));
      viol_raw[8] = acc && (HSIZE > MAX_SIZE);
      viol_raw[9] = (MAX_WAIT != 0) && !HREADY && (wait_q == WAIT_LIM);

      viol_v = viol_raw & chk_en;
      any_v  = |viol_v;

      state_d = state_q;
      burst_d = burst_q;
      size_d  = size_q;
      write_d = write_q;
      beat_d  = beat_q;
      exp_d   = exp_q;
      prev_d  = prev_q;
      err_d   = err_q;
      ended_d = ended_q;

      if (acc_nseq) begin
         burst_d = HBURST;
         size_d  = HSIZE;
         write_d = HWRITE;
         beat_d  = 5'd1;
         exp_d   = next_addr(HADDR, HSIZE, HBURST);
         prev_d  = HADDR;
         err_d   = 1'b0;
         ended_d = 1'b0;
         state_d = (HBURST != B_SINGLE) ? S_IN_BURST : S_NO_BURST;
      end else begin
         if (in_burst && (HRESP != R_OKAY)) err_d = 1'b1;
         if (resp1_q && HREADY) begin
            state_d = S_NO_BURST;
            ended_d = 1'b0;
         end else if (HREADY) begin
            case (HTRANS)
               T_IDLE: begin
                  state_d = S_NO_BURST;
                  ended_d = 1'b0;
               end
               T_BUSY: if (state_q == S_IN_BURST) state_d = S_IN_BUSY;
               T_SEQ: if (in_burst) begin
                  beat_d  = beat_inc;
                  exp_d   = next_addr(HADDR, size_q, burst_q);
                  prev_d  = HADDR;
                  state_d = final_beat ? S_NO_BURST : S_IN_BURST;
                  ended_d = final_beat;
               end
               default: ;
            endcase
         end
      end

      resp1_d   = resp1_q ? 1'b0 : ((HRESP != R_OKAY) && !HREADY);
      resp_d    = resp1_q ? resp_q : HRESP;
      idle_dp_d = HREADY ? ((HTRANS == T_IDLE) || (HTRANS == T_BUSY)) : idle_dp_q;
      wait_d    = HREADY ? '0 : ((wait_q == WAIT_SAT) ? wait_q : wait_q + WW'(1));

      // A violation on the clr edge is applied on top of the cleared state
      pulse_d  = viol_v;
      sticky_d = clr ? viol_v : (sticky_q | viol_v);
      if (clr)                         cnt_d = any_v ? CNT_W'(1) : '0;
      else if (any_v && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      else                             cnt_d = cnt_q;
      fvalid_d = (clr ? 1'b0 : fvalid_q) || any_v;
      faddr_d  = (any_v && (clr || !fvalid_q)) ? HADDR : faddr_q;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= S_NO_BURST;
         burst_q   <= '0;
         size_q    <= '0;
         write_q   <= 1'b0;
         beat_q    <= '0;
         exp_q     <= '0;
         prev_q    <= '0;
         err_q     <= 1'b0;
         ended_q   <= 1'b0;
         resp1_q   <= 1'b0;
         resp_q    <= '0;
         idle_dp_q <= 1'b0;
         wait_q    <= '0;
         pulse_q   <= '0;
         sticky_q  <= '0;
         cnt_q     <= '0;
         faddr_q   <= '0;
         fvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         burst_q   <= burst_d;
         size_q    <= size_d;
         write_q   <= write_d;
         beat_q    <= beat_d;
         exp_q     <= exp_d;
         prev_q    <= prev_d;
         err_q     <= err_d;
         ended_q   <= ended_d;
         resp1_q   <= resp1_d;
         resp_q    <= resp_d;
         idle_dp_q <= idle_dp_d;
         wait_q    <= wait_d;
         pulse_q   <= pulse_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
         faddr_q   <= faddr_d;
         fvalid_q  <= fvalid_d;
      end
   end

   assign viol_pulse   = pulse_q;
   assign viol_sticky  = sticky_q;
   assign viol_count   = cnt_q;
   assign first_addr   = faddr_q;
   assign first_valid  = fvalid_q;
   assign burst_active = (state_q != S_NO_BURST);
   assign beat_cnt     = beat_q;

endmodule

// File: tb/tb_ahb_proto_checker.sv
// Directed bench for ahb_proto_checker (32-bit bus, CNT_W=4, MAX_WAIT=4).
module tb_ahb_proto_checker;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
   localparam logic [1:0] OKAY = 2'd0, ERROR = 2'd1;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [9:0]  chk_en;
   logic        clr;
   logic [9:0]  viol_pulse;
   logic [9:0]  viol_sticky;
   logic [3:0]  viol_count;
   logic [31:0] first_addr;
   logic        first_valid;
   logic        burst_active;
   logic [4:0]  beat_cnt;

   int n_cmp = 0;
   int n_err = 0;

   ahb_proto_checker #(.ADDR_W(32), .DATA_W(32), .CNT_W(4), .MAX_WAIT(4), .NCHK(10)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
      .HWRITE(HWRITE), .HADDR(HADDR), .HREADY(HREADY), .HRESP(HRESP), .chk_en(chk_en),
      .clr(clr), .viol_pulse(viol_pulse), .viol_sticky(viol_sticky), .viol_count(viol_count),
      .first_addr(first_addr), .first_valid(first_valid), .burst_active(burst_active),
      .beat_cnt(beat_cnt)
   );

   always #5 HCLK = ~HCLK;

   task automatic cyc(input logic [1:0] t, input logic [2:0] b, input logic [2:0] s,
                      input logic w, input logic [31:0] a, input logic rdy, input logic [1:0] r);
      HTRANS = t; HBURST = b; HSIZE = s; HWRITE = w; HADDR = a; HREADY = rdy; HRESP = r;
      @(posedge HCLK); #1;
   endtask

   task automatic clear_cycle();
      clr = 1'b1;
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      HRESET = 1'b1; clr = 1'b0; chk_en = 10'h3FF;
      HTRANS = IDLE; HBURST = 0; HSIZE = 3'd2; HWRITE = 0; HADDR = 0; HREADY = 1; HRESP = OKAY;
      #2;
      n_cmp++;
      if ({viol_pulse, viol_sticky, viol_count, first_addr, first_valid, burst_active, beat_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: pulse=%h sticky=%h cnt=%0d faddr=%h fv=%b ba=%b beat=%0d, want all 0",
                  viol_pulse, viol_sticky, viol_count, first_addr, first_valid, burst_active, beat_cnt);
      end
      #21 HRESET = 1'b0;
      @(posedge HCLK); #1;
      n_cmp++;
      if (viol_sticky !== 10'h000) begin
         n_err++; $display("FAIL reset_idle_sticky: got %h want 000", viol_sticky);
      end
   endtask

   task automatic test_wrap4();
      clear_cycle();
      cyc(NSEQ, 3'd2, 3'd2, 1'b0, 32'h38, 1'b1, OKAY);
      cyc(SEQ,  3'd2, 3'd2, 1'b0, 32'h3C, 1'b1, OKAY);
      n_cmp++;
      if (burst_active !== 1'b1 || beat_cnt !== 5'd2) begin
         n_err++; $display("FAIL wrap4_mid: active=%b beat=%0d want 1/2", burst_active, beat_cnt);
      end
      cyc(SEQ,  3'd2, 3'd2, 1'b0, 32'h30, 1'b1, OKAY);
      cyc(SEQ,  3'd2, 3'd2, 1'b0, 32'h34, 1'b1, OKAY);
      n_cmp++;
      if (viol_sticky !== 10'h000) begin
         n_err++; $display("FAIL wrap4_sticky: got %h want 000", viol_sticky);
      end
      n_cmp++;
      if (beat_cnt !== 5'd4 || burst_active !== 1'b0) begin
         n_err++; $display("FAIL wrap4_end: beat=%0d active=%b want 4/0", beat_cnt, burst_active);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
   endtask

   task automatic test_addr_seq();
      clear_cycle();
      cyc(NSEQ, 3'd3, 3'd2, 1'b0, 32'h100, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h104, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h10C, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h008) begin
         n_err++; $display("FAIL addr_seq_pulse: got %h want 008", viol_pulse);
      end
      n_cmp++;
      if (viol_count !== 4'd1 || first_addr !== 32'h10C || first_valid !== 1'b1) begin
         n_err++; $display("FAIL addr_seq_first: cnt=%0d faddr=%h fv=%b want 1/0000010c/1",
                           viol_count, first_addr, first_valid);
      end
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h110, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h000 || burst_active !== 1'b0) begin
         n_err++; $display("FAIL addr_seq_last: pulse=%h active=%b want 000/0", viol_pulse, burst_active);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
   endtask

   task automatic test_resp_error();
      clear_cycle();
      cyc(NSEQ, 3'd5, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      cyc(SEQ,  3'd5, 3'd2, 1'b0, 32'h4, 1'b1, OKAY);
      cyc(SEQ,  3'd5, 3'd2, 1'b0, 32'h8, 1'b0, ERROR);
      n_cmp++;
      if (viol_pulse !== 10'h000) begin
         n_err++; $display("FAIL err_cycle1: got %h want 000", viol_pulse);
      end
      cyc(NSEQ, 3'd0, 3'd2, 1'b0, 32'h40, 1'b1, ERROR);
      n_cmp++;
      if (viol_pulse !== 10'h001) begin
         n_err++; $display("FAIL err_nonseq_cycle2: got %h want 001", viol_pulse);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      // legal two-cycle error that terminates an INCR4 early
      cyc(NSEQ, 3'd3, 3'd2, 1'b0, 32'h80, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h84, 1'b0, ERROR);
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, ERROR);
      n_cmp++;
      if (viol_pulse !== 10'h000 || burst_active !== 1'b0) begin
         n_err++; $display("FAIL err_legal: pulse=%h active=%b want 000/0", viol_pulse, burst_active);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      n_cmp++;
      if (viol_sticky !== 10'h001) begin
         n_err++; $display("FAIL err_sticky: got %h want 001", viol_sticky);
      end
   endtask

   task automatic test_align_size();
      clear_cycle();
      cyc(NSEQ, 3'd0, 3'd3, 1'b0, 32'h102, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h140 || viol_count !== 4'd1) begin
         n_err++; $display("FAIL align_size_both: pulse=%h cnt=%0d want 140/1", viol_pulse, viol_count);
      end
      cyc(NSEQ, 3'd0, 3'd2, 1'b0, 32'h102, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h040 || viol_count !== 4'd2) begin
         n_err++; $display("FAIL align_only: pulse=%h cnt=%0d want 040/2", viol_pulse, viol_count);
      end
      chk_en = 10'h3BF;
      cyc(NSEQ, 3'd0, 3'd2, 1'b0, 32'h102, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h000 || viol_count !== 4'd2) begin
         n_err++; $display("FAIL align_masked: pulse=%h cnt=%0d want 000/2", viol_pulse, viol_count);
      end
      chk_en = 10'h3FF;
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
   endtask

   task automatic test_ctrl_kb();
      clear_cycle();
      cyc(NSEQ, 3'd3, 3'd2, 1'b1, 32'h500, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h504, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h010) begin
         n_err++; $display("FAIL ctrl_seq: got %h want 010", viol_pulse);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h080) begin
         n_err++; $display("FAIL burst_len_early: got %h want 080", viol_pulse);
      end
      cyc(NSEQ, 3'd1, 3'd2, 1'b0, 32'h3FC, 1'b1, OKAY);
      cyc(SEQ,  3'd1, 3'd2, 1'b0, 32'h400, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h020) begin
         n_err++; $display("FAIL kb_cross: got %h want 020", viol_pulse);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h000) begin
         n_err++; $display("FAIL incr_idle_end: got %h want 000", viol_pulse);
      end
   endtask

   task automatic test_back_to_back();
      clear_cycle();
      cyc(NSEQ, 3'd3, 3'd2, 1'b0, 32'h300, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h304, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h308, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h30C, 1'b1, OKAY);
      cyc(SEQ,  3'd3, 3'd2, 1'b0, 32'h310, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h080) begin
         n_err++; $display("FAIL seq_after_last: got %h want 080", viol_pulse);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b0, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h002) begin
         n_err++; $display("FAIL idle_ok: got %h want 002", viol_pulse);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
   endtask

   task automatic test_stall();
      logic [9:0] exp_p;
      clear_cycle();
      cyc(NSEQ, 3'd1, 3'd2, 1'b0, 32'h200, 1'b1, OKAY);
      for (int i = 0; i < 6; i++) begin
         cyc(SEQ, 3'd1, 3'd2, 1'b0, 32'h204, 1'b0, OKAY);
         exp_p = (i == 4) ? 10'h200 : 10'h000;
         n_cmp++;
         if (viol_pulse !== exp_p) begin
            n_err++; $display("FAIL stall_low%0d: got %h want %h", i + 1, viol_pulse, exp_p);
         end
      end
      cyc(SEQ, 3'd1, 3'd2, 1'b0, 32'h204, 1'b1, OKAY);
      n_cmp++;
      if (viol_count !== 4'd1) begin
         n_err++; $display("FAIL stall_count: got %0d want 1", viol_count);
      end
      cyc(IDLE, 3'd0, 3'd2, 1'b0, 32'h0, 1'b1, OKAY);
      clr = 1'b1;
      cyc(BUSY, 3'd0, 3'd2, 1'b0, 32'h7F0, 1'b1, OKAY);
      clr = 1'b0;
      n_cmp++;
      if (viol_count !== 4'd1 || viol_sticky !== 10'h004 || first_addr !== 32'h7F0) begin
         n_err++; $display("FAIL clr_with_viol: cnt=%0d sticky=%h faddr=%h want 1/004/000007f0",
                           viol_count, viol_sticky, first_addr);
      end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_c;
      clear_cycle();
      for (int i = 0; i < 17; i++) begin
         cyc(BUSY, 3'd0, 3'd2, 1'b0, 32'h10, 1'b1, OKAY);
         exp_c = (i >= 14) ? 4'd15 : 4'(i + 1);
         n_cmp++;
         if (viol_count !== exp_c) begin
            n_err++; $display("FAIL sat_count%0d: got %0d want %0d", i + 1, viol_count, exp_c);
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc(NSEQ, 3'd7, 3'd2, 1'b0, 32'h600, 1'b1, OKAY);
      cyc(SEQ,  3'd7, 3'd2, 1'b0, 32'h604, 1'b1, OKAY);
      cyc(SEQ,  3'd7, 3'd2, 1'b0, 32'h608, 1'b1, OKAY);
      n_cmp++;
      if (burst_active !== 1'b1 || beat_cnt !== 5'd3) begin
         n_err++; $display("FAIL incr16_mid: active=%b beat=%0d want 1/3", burst_active, beat_cnt);
      end
      #3 HRESET = 1'b1;
      #1;
      n_cmp++;
      if ({viol_pulse, viol_sticky, viol_count, first_addr, first_valid, burst_active, beat_cnt} !== '0) begin
         n_err++;
         $display("FAIL async_reset: pulse=%h sticky=%h cnt=%0d faddr=%h fv=%b ba=%b beat=%0d, want all 0",
                  viol_pulse, viol_sticky, viol_count, first_addr, first_valid, burst_active, beat_cnt);
      end
      HTRANS = IDLE; HREADY = 1'b1;
      #2 HRESET = 1'b0;
      @(posedge HCLK); #1;
      cyc(SEQ, 3'd7, 3'd2, 1'b0, 32'h60C, 1'b1, OKAY);
      n_cmp++;
      if (viol_pulse !== 10'h000 || burst_active !== 1'b0) begin
         n_err++; $display("FAIL post_reset_seq: pulse=%h active=%b want 000/0", viol_pulse, burst_active);
      end
   endtask

   initial begin
      test_reset();
      test_wrap4();
      test_addr_seq();
      test_resp_error();
      test_align_size();
      test_ctrl_kb();
      test_back_to_back();
      test_stall();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_proto_checker.md
Name: ahb_proto_checker

Overview:
Synthesizable, parametrised AHB protocol checker that passively snoops one master/slave AHB bus and flags rule violations in hardware. It tracks burst state, computes expected SEQ addresses for INCR and WRAP bursts, and checks response, alignment and wait-state rules. It reports per-rule pulses, sticky flags, a saturating violation counter and the first offending address. It sits beside the bus in both the testbench and emulation builds.

Parameters:
ADDR_W, 32, address width (32..64)
DATA_W, 32, data bus width (32, 64, 128, 256, 512 or 1024); sets the legal HSIZE range
CNT_W, 16, violation counter width
MAX_WAIT, 16, maximum consecutive HREADY-low cycles; 0 disables the STALL rule
NCHK, 10, number of rules (fixed at 10, exposed for width use)

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous reset, active-high
HTRANS  in  2  0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
HBURST  in  3  0=SINGLE 1=INCR 2=WRAP4 3=INCR4 4=WRAP8 5=INCR8 6=WRAP16 7=INCR16
HSIZE  in  3  transfer size, 2**HSIZE bytes
HWRITE  in  1  write when 1
HADDR  in  ADDR_W  address
HREADY  in  1  transfer done / ready
HRESP  in  2  0=OKAY 1=ERROR 2=RETRY 3=SPLIT
chk_en  in  NCHK  per-rule enable mask
clr  in  1  synchronous clear of sticky flags, counter and first-capture
viol_pulse  out  NCHK  one-cycle flag per violated rule
viol_sticky  out  NCHK  accumulated flags
viol_count  out  CNT_W  number of cycles with at least one enabled violation, saturating
first_addr  out  ADDR_W  HADDR latched at the first violation since reset/clr
first_valid  out  1  first_addr is valid
burst_active  out  1  checker is tracking a burst
beat_cnt  out  5  beats accepted in the current burst

Behaviour:
- Reset (HRESET high, async): all outputs 0; FSM to NO_BURST; expected address 0; wait counter 0.
- Accepted address phase: a posedge with HREADY=1 and HTRANS equal to NONSEQ or SEQ.
- Rules are evaluated on each posedge and masked by chk_en. viol_pulse, viol_sticky, viol_count and first_addr update on the following edge (1-cycle latency).
- Rule bits:
  - 0 RESP2: a non-OKAY HRESP must be two cycles. Cycle 1 has HREADY=0; cycle 2 has the same HRESP with HREADY=1; HTRANS must be IDLE in cycle 2. Any deviation flags.
  - 1 IDLE_OK: the data phase following an accepted IDLE or BUSY must show HRESP=OKAY with HREADY=1.
  - 2 BUSY_ILLEGAL: BUSY while in NO_BURST or while the burst is SINGLE.
  - 3 ADDR_SEQ: SEQ HADDR must equal the expected address.
  - 4 CTRL_SEQ: on SEQ, HBURST, HSIZE and HWRITE must match the burst's NONSEQ values.
  - 5 KB_CROSS: an INCR-type SEQ address whose bit 10 upward differs from the previous beat's.
  - 6 ALIGN: HADDR must be a multiple of 2**HSIZE on accepted transfers.
  - 7 BURST_LEN: SEQ after the last beat of a fixed-length burst. Also flags NONSEQ or IDLE before the last beat, unless an ERROR/RETRY/SPLIT was seen during the burst.
  - 8 SIZE_WIDTH: 2**HSIZE*8 > DATA_W on an accepted transfer.
  - 9 STALL: HREADY low for more than MAX_WAIT consecutive cycles. Flags once per stall episode.
- FSM:
  - NO_BURST to IN_BURST on an accepted NONSEQ with HBURST != SINGLE. Latch HBURST, HSIZE and HWRITE; set beat_cnt=1.
  - IN_BURST to IN_BUSY on BUSY.
  - IN_BUSY to IN_BURST on SEQ.
  - Any state to NO_BURST on IDLE, on the final beat of a fixed-length burst, or on the second cycle of a non-OKAY response.
  - NONSEQ in any state restarts the burst.
  - beat_cnt increments on each accepted SEQ and saturates at 31 (undefined-length INCR).
- Expected address, with b = 2**HSIZE:
  - INCR types: prev+b, computed at ADDR_W width with wrap-around.
  - WRAPn: boundary B = n*b; next = (prev & ~(B-1)) | ((prev+b) & (B-1)).
  - The expected address holds during BUSY and is not updated while HREADY=0.
- Counter: increments by exactly 1 per cycle with any enabled violation, regardless of how many bits are set. It holds at 2**CNT_W-1.
- first_addr: latched only when first_valid=0. It captures the HADDR sampled on the violating edge.
- clr: clears sticky flags, count and first_valid in one cycle. A violation sampled on the same edge as clr is applied after the clear, so it is recorded.
- clr does not affect the FSM, the expected address or viol_pulse.
- HRESET mid-burst returns the FSM to NO_BURST immediately. The first post-reset SEQ without a NONSEQ flags BURST_LEN only if it follows a tracked burst; otherwise it is ignored.

Test Plan:
- WRAP4 word at 0x38: 0x38, 0x3C, 0x30, 0x34 all SEQ with HREADY=1 -> viol_sticky=0, beat_cnt=4, burst_active=0 after the last beat.
- INCR4 word at 0x100 with the 3rd beat at 0x10C -> viol_pulse[3]=1 one cycle later, viol_count=1, first_addr=0x10C, first_valid=1.
- ERROR response with HTRANS=NONSEQ in the 2nd response cycle -> viol_pulse[0]=1. An INCR8 cut short by that error does not set bit 7.
- HSIZE=2 at 0x102, and HSIZE=3 with DATA_W=32 -> bits 6 and 8 set on the same edge; viol_count increments by 1 only.
- MAX_WAIT=4 with HREADY low for 6 cycles -> viol_pulse[9] pulses once (on the 5th low cycle + 1). A second violation while clr=1 -> viol_count=1 and the sticky bit is set.
- viol_count preset near saturation with CNT_W=4: 17 violating cycles -> viol_count=15. HRESET asserted mid-INCR16 -> all outputs 0 asynchronously.
